video_raster_timing: RTL

Parametrised raster timing generator for the video subsystem. Driven by the PLL pixel clock, it produces HSYNC, VSYNC, the data-enable signal and aligned pixel coordinates for any VESA-style mode, with programmable sync polarity. It also provides frame and vblank markers and a CPU-facing line-compare interrupt with acknowledge handshake for the 68k side.

---
 rtl/video_timing_pkg.sv | 41 ++++
 rtl/video_axis_counter.sv | 53 +++++
 rtl/video_raster_timing.sv | 133 +++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Mode table and shared widths for the raster timing generator.
package video_timing_pkg;

    localparam int unsigned FRAME_COUNT_W = 16;

    // 720p60 runs at 74.25 MHz, 800x600@60 at 40 MHz, 640x480@60 at 25.175 MHz.
    typedef enum logic [1:0] {
        MODE_720P60     = 2'd0,
        MODE_800X600_60 = 2'd1,
        MODE_640X480_60 = 2'd2
    } video_mode_e;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_active;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
        logic        hsync_pol;
        logic        vsync_pol;
    } mode_timing_t;

    function automatic mode_timing_t mode_timing(video_mode_e mode);
        mode_timing_t t;
        case (mode)
            MODE_800X600_60: t = '{32'd800, 32'd40, 32'd128, 32'd88,
                                   32'd600, 32'd1, 32'd4, 32'd23, 1'b1, 1'b1};
            MODE_640X480_60: t = '{32'd640, 32'd16, 32'd96, 32'd48,
                                   32'd480, 32'd10, 32'd2, 32'd33, 1'b0, 1'b0};
            default:         t = '{32'd1280, 32'd110, 32'd40, 32'd220,
                                   32'd720, 32'd5, 32'd5, 32'd20, 1'b1, 1'b1};
        endcase
        return t;
    endfunction

    localparam mode_timing_t MODE_DEFAULT = mode_timing(MODE_720P60);

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter plus active/sync segment decodes.
module video_axis_counter #(
    parameter int unsigned ACTIVE = 8,
    parameter int unsigned FRONT  = 2,
    parameter int unsigned SYNC   = 2,
    parameter int unsigned BACK   = 4,
    parameter int unsigned W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;
    localparam int unsigned XW    = W + 1;

    // Segment bounds carry one spare bit so a segment ending exactly at 2^W still compares correctly.
    localparam logic [W:0]   ACTIVE_END = XW'(ACTIVE);
    localparam logic [W:0]   SYNC_START = XW'(ACTIVE + FRONT);
    localparam logic [W:0]   SYNC_END   = XW'(ACTIVE + FRONT + SYNC);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    logic [W:0]   count_x;

    always_comb begin
        // NOTE: default assigned first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_x   = {1'b0, count_q};
    assign count     = count_q;
    assign wrap      = step && (count_q == LAST);
    assign in_active = (count_x < ACTIVE_END);
    assign in_sync   = (count_x >= SYNC_START) && (count_x < SYNC_END);

endmodule

// File: rtl/video_raster_timing.sv
// Raster timing generator: registered sync/DE/coordinate outputs, frame/vblank pulses,
// completed-frame counter and a sticky line-compare interrupt with acknowledge.
module video_raster_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = MODE_DEFAULT.h_active,
    parameter int unsigned H_FRONT   = MODE_DEFAULT.h_front,
    parameter int unsigned H_SYNC    = MODE_DEFAULT.h_sync,
    parameter int unsigned H_BACK    = MODE_DEFAULT.h_back,
    parameter int unsigned V_ACTIVE  = MODE_DEFAULT.v_active,
    parameter int unsigned V_FRONT   = MODE_DEFAULT.v_front,
    parameter int unsigned V_SYNC    = MODE_DEFAULT.v_sync,
    parameter int unsigned V_BACK    = MODE_DEFAULT.v_back,
    parameter bit          HSYNC_POL = MODE_DEFAULT.hsync_pol,
    parameter bit          VSYNC_POL = MODE_DEFAULT.vsync_pol,
    parameter int unsigned X_W       = 11,
    parameter int unsigned Y_W       = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     irq_en,
    input  logic [Y_W-1:0]           irq_line,
    input  logic                     irq_ack,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     visible,
    output logic [X_W-1:0]           pixel_x,
    output logic [Y_W-1:0]           pixel_y,
    output logic                     frame_start,
    output logic                     vblank_start,
    output logic                     line_irq,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam logic [X_W-1:0] IRQ_COL    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] VBLANK_ROW = Y_W'(V_ACTIVE);

    logic [X_W-1:0] h_count;
    logic           h_wrap, h_active, h_sync;
    logic [Y_W-1:0] v_count;
    logic           v_wrap, v_active, v_sync;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (X_W)
    ) u_h_counter (
        .clk       (clk),
        .reset     (reset),
        .step      (1'b1),
        .count     (h_count),
        .wrap      (h_wrap),
        .in_active (h_active),
        .in_sync   (h_sync)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (Y_W)
    ) u_v_counter (
        .clk       (clk),
        .reset     (reset),
        .step      (h_wrap),
        .count     (v_count),
        .wrap      (v_wrap),
        .in_active (v_active),
        .in_sync   (v_sync)
    );

    logic at_origin, at_vblank, irq_hit;

    always_comb begin
        at_origin = (h_count == '0) && (v_count == '0);
        at_vblank = (h_count == '0) && (v_count == VBLANK_ROW);
        irq_hit   = irq_en && (h_count == IRQ_COL) && (v_count == irq_line);
    end

    logic                     hsync_q, vsync_q, visible_q;
    logic [X_W-1:0]           pixel_x_q;
    logic [Y_W-1:0]           pixel_y_q;
    logic                     frame_start_q, vblank_start_q;
    logic                     line_irq_q, line_irq_d;
    logic                     frame_wrap_q;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

    // Set beats a simultaneous acknowledge; a low irq_en only blocks new sets.
    assign line_irq_d = irq_hit || (line_irq_q && !irq_ack);

    // The wrap is delayed one stage so the count steps together with the frame_start output.
    assign frame_count_d = frame_wrap_q ? frame_count_q + FRAME_COUNT_W'(1) : frame_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q        <= ~HSYNC_POL;
            vsync_q        <= ~VSYNC_POL;
            visible_q      <= 1'b0;
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            line_irq_q     <= 1'b0;
            frame_wrap_q   <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            hsync_q        <= h_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync_q        <= v_sync ? VSYNC_POL : ~VSYNC_POL;
            visible_q      <= h_active && v_active;
            pixel_x_q      <= h_count;
            pixel_y_q      <= v_count;
            frame_start_q  <= at_origin;
            vblank_start_q <= at_vblank;
            line_irq_q     <= line_irq_d;
            frame_wrap_q   <= v_wrap;
            frame_count_q  <= frame_count_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign visible      = visible_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign line_irq     = line_irq_q;
    assign frame_count  = frame_count_q;

endmodule
